parking_gate_ctrl: RTL
======================

// Module: parking_gate_ctrl
// PURPOSE
//  Sequences the single shared barrier gate of the car park between the entry and exit lane
//  sensors and keeps the authoritative occupancy count against a keyboard-set capacity.
//  Sits between the raw lane sensors / PS/2 digit decoder and the seven-segment, buzzer and
//  "FULL" display logic. Only one car moves through the gate at a time.
// PARAMETERS
//  CAP_DEF      2           capacity after reset (0..9)
//  HOLD_CYC     16          cycles the gate stays open after the car clears the sensor
//  TIMEOUT_CYC  1024        max cycles in OPEN waiting for the car to pass before abort
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  reset, asynchronous, active-low
//  entry_sns    in   1  entry lane sensor, active-low (0 = car present), asynchronous
//  exit_sns     in   1  exit lane sensor, active-low, asynchronous
//  cap_max      in   4  new capacity, binary 0..9 (from keyboard digit decode)
//  cap_valid    in   1  1-cycle strobe: load cap_max
//  gate_open    out  1  1 = barrier raised
//  serve_entry  out  1  1 = gate currently granted to entry lane
//  serve_exit   out  1  1 = gate currently granted to exit lane
//  occupancy    out  4  cars inside, 0..9
//  full         out  1  occupancy >= capacity
//  buzzer       out  1  1 while full and an entry request is pending
//  err_timeout  out  1  1-cycle pulse on OPEN timeout abort
// BEHAVIOUR
//  Clock/reset: one clock. Reset is asynchronous and active-low (rst_n); all regs clear at once.
//  Reset values: gate_open=0, serve_*=0, occupancy=0, capacity=CAP_DEF, full=(CAP_DEF==0),
//   buzzer=0, err_timeout=0, pending requests cleared, last_grant=ENTRY.
//  Inputs: each sensor through a 2-flop synchronizer; a request is latched on the synchronized
//   1->0 edge; request is sticky until granted or aborted; repeat edges while pending are ignored.
//  Capacity: on cap_valid, capacity<=cap_max if cap_max<=9, else ignored. Lowering capacity below
//   occupancy is legal: full=1, occupancy unchanged, entries blocked until exits bring it below.
//  FSM states IDLE, OPEN, HOLD:
//   IDLE: eligible = exit_req | (entry_req & ~full). None -> stay. One -> grant it.
//    Both -> grant lane opposite to last_grant (round-robin; after reset exit wins).
//    Grant: next cycle state=OPEN, gate_open=1, serve_x=1, req_x cleared, last_grant=x.
//   OPEN: wait for served sensor (synchronized) to return to 1 -> HOLD, hold counter=0.
//    Timer reaching TIMEOUT_CYC -> IDLE, gate_open=0, err_timeout pulse, occupancy unchanged.
//   HOLD: gate stays open HOLD_CYC cycles, then IDLE, gate_open=0, serve_x=0, and in the same
//    cycle occupancy +1 (entry, saturate at 9) or -1 (exit, saturate at 0).
//  Latency: request edge at sensor -> gate_open=1 in 3 cycles min (2 sync + 1 grant).
//  Requests arriving during OPEN/HOLD stay pending, served on return to IDLE (one IDLE cycle min).
//  Exit at occupancy 0: gate still cycles, count stays 0 (car left over from reset).
//  Entry pending while full: not granted, buzzer=1; buzzer drops as soon as full clears.
//  full/buzzer are registered, valid the cycle after occupancy/capacity changes.
//  Reset mid-cycle: gate drops immediately, in-flight pass lost, occupancy returns to 0.
// TESTING
//  1 entry pulse (sns low 5 cyc, then high), cap=2 -> gate_open 3 cyc after edge, HOLD_CYC, occ 0->1.
//  2 entry and exit edges same cycle, occ=1 after reset -> exit served first, then entry; occ ends 1.
//  3 cap=1, occ=1, entry edge -> no grant, buzzer=1, full=1; exit pass -> occ 0, entry then served.
//  4 entry edge, sensor held low TIMEOUT_CYC -> err_timeout 1-cycle pulse, gate closes, occ unchanged.
//  5 cap_valid with cap_max=0 at occ=2 -> full=1; cap_max=12 ignored; two exits -> occ 0, full stays 1.
//  6 rst_n low during HOLD of entry -> gate_open=0 asynchronously, occ=0, capacity=CAP_DEF.

Source files
------------

// File: rtl/parking_gate_if.sv
// Signal bundle between the lane sensors / keyboard decode and the gate controller.
// The master drives sensors and capacity; the slave (controller) drives gate and status.
interface parking_gate_if;
  logic       entry_sns;
  logic       exit_sns;
  logic [3:0] cap_max;
  logic       cap_valid;
  logic       gate_open;
  logic       serve_entry;
  logic       serve_exit;
  logic [3:0] occupancy;
  logic       full;
  logic       buzzer;
  logic       err_timeout;

  modport master (
    output entry_sns, exit_sns, cap_max, cap_valid,
    input  gate_open, serve_entry, serve_exit, occupancy, full, buzzer, err_timeout
  );

  modport slave (
    input  entry_sns, exit_sns, cap_max, cap_valid,
    output gate_open, serve_entry, serve_exit, occupancy, full, buzzer, err_timeout
  );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Shared barrier sequencer for the entry and exit lanes; owns the occupancy count
// and the keyboard-set capacity.
//
//  state | meaning
//  IDLE  | gate down, arbitrating pending lane requests
//  OPEN  | gate up, waiting for the served car to clear its sensor (with timeout)
//  HOLD  | gate up for HOLD_CYC after the car cleared, then count the pass
module parking_gate_ctrl #(
  parameter int CAP_DEF     = 2,
  parameter int HOLD_CYC    = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  parking_gate_if.slave  bus
);

  localparam int         TMAX    = (TIMEOUT_CYC > HOLD_CYC) ? TIMEOUT_CYC : HOLD_CYC;
  localparam int         TW      = $clog2(TMAX) + 1;
  localparam logic [3:0] CAP_RST = 4'(CAP_DEF);
  localparam logic [3:0] OCC_MAX = 4'd9;

  typedef enum logic [1:0] {IDLE, OPEN, HOLD} state_t;

  state_t        state;
  logic [2:0]    ent_sync;
  logic [2:0]    ext_sync;
  logic          entry_req;
  logic          exit_req;
  logic          last_exit;
  logic          lane_exit;
  logic [3:0]    capacity;
  logic [3:0]    occupancy;
  logic [TW-1:0] timer;
  logic          gate_open;
  logic          serve_entry;
  logic          serve_exit;
  logic          full;
  logic          buzzer;
  logic          err_timeout;

  logic entry_fall;
  logic exit_fall;
  logic entry_pend;
  logic exit_pend;
  logic full_now;
  logic elig_entry;
  logic elig_exit;
  logic grant_exit;
  logic served_clear;

  // Arbitration uses the unregistered full so an entry cannot slip through in the
  // cycle where the count has just reached capacity but the full flag lags.
  always_comb begin
    entry_fall   = ent_sync[2] & ~ent_sync[1];
    exit_fall    = ext_sync[2] & ~ext_sync[1];
    entry_pend   = entry_req | entry_fall;
    exit_pend    = exit_req | exit_fall;
    full_now     = (occupancy >= capacity);
    elig_exit    = exit_pend;
    elig_entry   = entry_pend & ~full_now;
    grant_exit   = elig_exit & (~elig_entry | ~last_exit);
    served_clear = lane_exit ? ext_sync[1] : ent_sync[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_sync <= 3'b111;
      ext_sync <= 3'b111;
      capacity <= CAP_RST;
      full     <= (CAP_RST == 4'd0);
      buzzer   <= 1'b0;
    end else begin
      ent_sync <= {ent_sync[1:0], bus.entry_sns};
      ext_sync <= {ext_sync[1:0], bus.exit_sns};
      if (bus.cap_valid && (bus.cap_max <= OCC_MAX)) begin
        capacity <= bus.cap_max;
      end
      full   <= full_now;
      buzzer <= full_now & entry_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      entry_req   <= 1'b0;
      exit_req    <= 1'b0;
      last_exit   <= 1'b0;
      lane_exit   <= 1'b0;
      timer       <= '0;
      occupancy   <= '0;
      gate_open   <= 1'b0;
      serve_entry <= 1'b0;
      serve_exit  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      entry_req   <= entry_pend;
      exit_req    <= exit_pend;
      case (state)
        IDLE: begin
          if (elig_entry || elig_exit) begin
            state       <= OPEN;
            gate_open   <= 1'b1;
            timer       <= TW'(TIMEOUT_CYC - 1);
            lane_exit   <= grant_exit;
            last_exit   <= grant_exit;
            serve_exit  <= grant_exit;
            serve_entry <= ~grant_exit;
            if (grant_exit) exit_req <= 1'b0;
            else            entry_req <= 1'b0;
          end
        end
        OPEN: begin
          if (served_clear) begin
            state <= HOLD;
            timer <= TW'(HOLD_CYC - 1);
          end else if (timer == '0) begin
            state       <= IDLE;
            gate_open   <= 1'b0;
            serve_entry <= 1'b0;
            serve_exit  <= 1'b0;
            err_timeout <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        HOLD: begin
          if (timer == '0) begin
            state       <= IDLE;
            gate_open   <= 1'b0;
            serve_entry <= 1'b0;
            serve_exit  <= 1'b0;
            // An exit at zero is a car left over from reset: gate cycles, count stays.
            if (lane_exit) begin
              if (occupancy != 4'd0) occupancy <= occupancy - 1'b1;
            end else begin
              if (occupancy < OCC_MAX) occupancy <= occupancy + 1'b1;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gate_open   = gate_open;
  assign bus.serve_entry = serve_entry;
  assign bus.serve_exit  = serve_exit;
  assign bus.occupancy   = occupancy;
  assign bus.full        = full;
  assign bus.buzzer      = buzzer;
  assign bus.err_timeout = err_timeout;

endmodule
